// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and default geometry for the 2-way cache
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_MISS,
        ST_WRITE,
        ST_FLUSH
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_INDEX_W = 7;
    localparam int DEF_CNT_W   = 16;

    // Geometry derived from the default parameter set
    localparam int                     TAG_W       = DEF_ADDR_W - DEF_INDEX_W;
    localparam int                     SETS        = 1 << DEF_INDEX_W;
    localparam logic [DEF_CNT_W-1:0]   COUNTER_MAX = '1;

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one way of the cache: data, tag and valid arrays
//
// Ports:
//   clk_1, rst          clock, synchronous active-low reset (clears valid bits only)
//   rd_index            combinational lookup index
//   rd_valid/tag/data   contents of the indexed line
//   wr_en/index/tag/data synchronous line write, marks the line valid
//   inv_en/inv_index    synchronous invalidate of one line
module cache_way
    import cache_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int TAG_BITS = TAG_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                clk_1,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                inv_en,
    input  logic [INDEX_W-1:0]  inv_index
);

    localparam int NUM_SETS = 1 << INDEX_W;

    logic [NUM_SETS-1:0] valid;
    logic [TAG_BITS-1:0] tag_mem  [NUM_SETS];
    logic [DATA_W-1:0]   data_mem [NUM_SETS];

    // Only valid bits are reset; tag/data contents are meaningless while invalid
    always_ff @(posedge clk_1) begin
        if (!rst) begin
            valid <= '0;
        end else begin
            if (inv_en) begin
                valid[inv_index] <= 1'b0;
            end
            if (wr_en) begin
                valid[wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/cache_2way.sv
// rtl/cache_2way.sv - 2-way set-associative write-through, no-write-allocate cache
//
// Ports:
//   clk_1, rst                   clock, synchronous active-low reset
//   cpu_req/we/addr/wdata        CPU request, sampled only when busy=0
//   flush                        invalidate whole cache, wins over cpu_req
//   cpu_rdata, cpu_ready, hit    registered completion (ready is a 1-cycle pulse)
//   busy                         high outside IDLE
//   mem_req/we/addr/wdata        memory request, held stable until mem_ack
//   mem_rdata, mem_ack           memory response
//   hit_cnt, miss_cnt            saturating hit/miss counters
module cache_2way
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              hit,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_BITS = ADDR_W - INDEX_W;
    localparam int NUM_SETS = 1 << INDEX_W;

    state_t              state;
    logic [NUM_SETS-1:0] lru;        // lru[i] names the least recently used way of set i
    logic [INDEX_W-1:0]  flush_idx;
    logic                wr_hit;     // lookup result of the write in flight

    logic [INDEX_W-1:0]  lk_index;
    logic [TAG_BITS-1:0] lk_tag;
    logic                v0, v1;
    logic [TAG_BITS-1:0] t0, t1;
    logic [DATA_W-1:0]   d0, d1;
    logic                hit0, hit1, lk_hit, lk_way;
    logic                victim, accept, fill;
    logic                wr_en0, wr_en1, inv_en;
    logic [DATA_W-1:0]   way_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // In IDLE the lookup uses the incoming request; afterwards the latched
    // mem_addr still carries the request address, so the refill reuses it.
    always_comb begin
        lk_index  = cpu_addr[INDEX_W-1:0];
        lk_tag    = cpu_addr[ADDR_W-1:INDEX_W];
        if (state != ST_IDLE) begin
            lk_index = mem_addr[INDEX_W-1:0];
            lk_tag   = mem_addr[ADDR_W-1:INDEX_W];
        end
        hit0      = v0 && (t0 == lk_tag);
        hit1      = v1 && (t1 == lk_tag) && !hit0;
        lk_hit    = hit0 || hit1;
        lk_way    = hit1;
        victim    = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[lk_index]);
        accept    = (state == ST_IDLE) && !flush && cpu_req;
        fill      = (state == ST_MISS) && mem_req && mem_ack;
        wr_en0    = rst && ((accept && cpu_we && hit0) || (fill && !victim));
        wr_en1    = rst && ((accept && cpu_we && hit1) || (fill && victim));
        inv_en    = (state == ST_FLUSH);
        way_wdata = fill ? mem_rdata : cpu_wdata;
    end

    cache_way #(.INDEX_W(INDEX_W), .TAG_BITS(TAG_BITS), .DATA_W(DATA_W)) u_way0 (
        .clk_1     (clk_1),
        .rst       (rst),
        .rd_index  (lk_index),
        .rd_valid  (v0),
        .rd_tag    (t0),
        .rd_data   (d0),
        .wr_en     (wr_en0),
        .wr_index  (lk_index),
        .wr_tag    (lk_tag),
        .wr_data   (way_wdata),
        .inv_en    (inv_en),
        .inv_index (flush_idx)
    );

    cache_way #(.INDEX_W(INDEX_W), .TAG_BITS(TAG_BITS), .DATA_W(DATA_W)) u_way1 (
        .clk_1     (clk_1),
        .rst       (rst),
        .rd_index  (lk_index),
        .rd_valid  (v1),
        .rd_tag    (t1),
        .rd_data   (d1),
        .wr_en     (wr_en1),
        .wr_index  (lk_index),
        .wr_tag    (lk_tag),
        .wr_data   (way_wdata),
        .inv_en    (inv_en),
        .inv_index (flush_idx)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk_1) begin
        if (!rst) begin
            state     <= ST_IDLE;
            lru       <= '0;
            flush_idx <= '0;
            wr_hit    <= 1'b0;
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        flush_idx <= '0;
                        state     <= ST_FLUSH;
                    end else if (cpu_req) begin
                        if (lk_hit) begin
                            lru[lk_index] <= ~lk_way;
                            hit_cnt       <= sat_inc(hit_cnt);
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                        end
                        if (cpu_we) begin
                            // Write-through regardless of hit; no allocation on miss
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            wr_hit    <= lk_hit;
                            state     <= ST_WRITE;
                        end else if (lk_hit) begin
                            cpu_rdata <= lk_way ? d1 : d0;
                            hit       <= 1'b1;
                            cpu_ready <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= cpu_addr;
                            state    <= ST_MISS;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                ST_MISS: begin
                    if (mem_req && mem_ack) begin
                        lru[lk_index] <= ~victim;
                        cpu_rdata     <= mem_rdata;
                        hit           <= 1'b0;
                        mem_req       <= 1'b0;
                        cpu_ready     <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    if (mem_req && mem_ack) begin
                        mem_req   <= 1'b0;
                        hit       <= wr_hit;
                        cpu_ready <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_FLUSH: begin
                    // Valid bits are cleared inside the ways via inv_en
                    lru[flush_idx] <= 1'b0;
                    if (flush_idx == {INDEX_W{1'b1}}) begin
                        state <= ST_IDLE;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_2way.sv
// tb/tb_cache_2way.sv - randomized self-checking bench for cache_2way
module tb_cache_2way;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int NSETS   = 128;

    logic        clk_1 = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        flush = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        hit;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    cache_2way #(.CNT_W(CNT_W)) dut (
        .clk_1     (clk_1),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .flush     (flush),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .hit       (hit),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk_1 = ~clk_1;

    int tests = 0;
    int fails = 0;

    // Reference model: set of cached addresses with last-use timestamps
    logic [7:0]  m_data  [int];
    int unsigned m_stamp [int];
    int unsigned now_t = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_1);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic m_touch(input int a);
        now_t++;
        m_stamp[a] = now_t;
    endtask

    task automatic m_clear;
        m_data.delete();
        m_stamp.delete();
    endtask

    // A set holds at most two lines; the least recently used one is evicted
    task automatic m_fill(input int a, input logic [7:0] d);
        int          cnt = 0;
        int          oldest_key = -1;
        int unsigned oldest = 32'hffff_ffff;
        foreach (m_data[k]) begin
            if ((k % NSETS) == (a % NSETS)) begin
                cnt++;
                if (m_stamp[k] < oldest) begin
                    oldest     = m_stamp[k];
                    oldest_key = k;
                end
            end
        end
        if (cnt >= 2) begin
            m_data.delete(oldest_key);
            m_stamp.delete(oldest_key);
        end
        m_data[a] = d;
        m_touch(a);
    endtask

    task automatic check_counters;
        check_eq("hit_cnt", 32'(hit_cnt), exp_hits);
        check_eq("miss_cnt", 32'(miss_cnt), exp_miss);
    endtask

    task automatic check_back_idle;
        tick;
        check_eq("back_idle", {cpu_ready, busy, mem_req}, 3'b000);
    endtask

    task automatic stall(input int dly, input logic we, input logic [15:0] a);
        for (int i = 0; i < dly; i++) begin
            tick;
            check_eq("stall", {mem_req, busy, cpu_ready, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, we, a});
        end
    endtask

    task automatic do_read(input int a, input int dly, input logic [7:0] rd);
        bit          h;
        logic [15:0] a16;
        h   = m_data.exists(a);
        a16 = a[15:0];
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a16;
        tick;
        cpu_req = 1'b0;
        if (h) begin
            m_touch(a);
            exp_hits = sat(exp_hits);
            check_eq("rd_hit", {cpu_ready, hit, mem_req, cpu_rdata}, {1'b1, 1'b1, 1'b0, m_data[a]});
        end else begin
            exp_miss = sat(exp_miss);
            check_eq("rd_miss_req", {mem_req, mem_we, cpu_ready, mem_addr}, {1'b1, 1'b0, 1'b0, a16});
            stall(dly, 1'b0, a16);
            mem_ack = 1'b1; mem_rdata = rd;
            tick;
            mem_ack = 1'b0;
            m_fill(a, rd);
            check_eq("rd_fill", {cpu_ready, hit, mem_req, cpu_rdata}, {1'b1, 1'b0, 1'b0, rd});
        end
        check_counters();
        check_back_idle();
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input int dly);
        bit          h;
        logic [15:0] a16;
        h   = m_data.exists(a);
        a16 = a[15:0];
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a16; cpu_wdata = d;
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (h) begin
            m_data[a] = d;
            m_touch(a);
            exp_hits = sat(exp_hits);
        end else begin
            exp_miss = sat(exp_miss);
        end
        check_eq("wr_issue", {mem_req, mem_we, cpu_ready, mem_addr, mem_wdata}, {1'b1, 1'b1, 1'b0, a16, d});
        stall(dly, 1'b1, a16);
        check_eq("wr_wdata", 32'(mem_wdata), 32'(d));
        mem_ack = 1'b1; mem_rdata = 8'($urandom);
        tick;
        mem_ack = 1'b0;
        check_eq("wr_done", {cpu_ready, hit, mem_req}, {1'b1, h, 1'b0});
        check_counters();
        check_back_idle();
    endtask

    task automatic do_flush(input bit with_req);
        int n = 0;
        int readies = 0;
        flush = 1'b1; cpu_req = with_req; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick;
        flush = 1'b0; cpu_req = 1'b0;
        while (busy && n < 300) begin
            n++;
            if (cpu_ready) readies++;
            tick;
        end
        m_clear();
        check_eq("flush_len", n, 128);
        check_eq("flush_no_ready", readies, 0);
        check_counters();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        tick; tick;
        check_eq("reset_flags", {cpu_ready, hit, busy, mem_req, mem_we}, 5'b00000);
        check_eq("reset_data", {cpu_rdata, mem_addr, mem_wdata}, 32'h0);
        check_counters();
        rst = 1'b1;
        tick;

        // Basic miss then hit
        do_read(16'h1234, 0, 8'hA5);
        check_eq("first_miss_cnt", 32'(miss_cnt), 1);
        do_read(16'h1234, 0, 8'h00);
        check_eq("first_hit_cnt", 32'(hit_cnt), 1);

        // LRU eviction within set 0x10
        do_read(16'h0010, 1, 8'h11);
        do_read(16'h0090, 0, 8'h22);
        do_read(16'h0010, 0, 8'h00);
        do_read(16'h0110, 2, 8'h33);
        do_read(16'h0010, 0, 8'h00);
        check_eq("lru_keep", {hit, cpu_rdata}, {1'b1, 8'h11});
        do_read(16'h0090, 0, 8'h44);
        check_eq("lru_evicted", 32'(hit), 0);

        // Write hit updates line, write miss does not allocate
        do_write(16'h0010, 8'h5A, 1);
        do_read(16'h0010, 0, 8'h00);
        check_eq("wr_hit_reread", {hit, cpu_rdata}, {1'b1, 8'h5A});
        do_write(16'h0200, 8'h77, 0);
        do_read(16'h0200, 0, 8'h78);
        check_eq("wr_miss_noalloc", 32'(hit), 0);

        // Long ack stall, then stray ack in IDLE
        do_read(16'h0333, 5, 8'h9C);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_eq("idle_ack", {cpu_ready, busy, mem_req}, 3'b000);

        // Flush beats simultaneous request
        do_flush(1'b1);
        do_read(16'h1234, 0, 8'hB6);
        check_eq("post_flush_miss", 32'(hit), 0);

        // Saturating hit counter
        for (int i = 0; i < 20; i++) do_read(16'h1234, 0, 8'h00);
        check_eq("hit_sat", 32'(hit_cnt), CNT_MAX);

        // Reset in the middle of a miss
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0444;
        tick;
        cpu_req = 1'b0;
        check_eq("pre_rst_req", 32'(mem_req), 1);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check_eq("rst_mid_miss", {mem_req, busy, cpu_ready}, 3'b000);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        check_eq("late_ack", {cpu_ready, busy, mem_req}, 3'b000);
        m_clear();
        exp_hits = 0;
        exp_miss = 0;
        check_counters();
        do_read(16'h1234, 0, 8'hC1);
        check_eq("rst_invalidated", 32'(hit), 0);

        // Randomized traffic over a few hot sets to force hits and evictions
        for (int n = 0; n < 300; n++) begin
            int r;
            int a;
            r = int'($urandom_range(0, 99));
            a = (int'($urandom_range(0, 3)) << 7) | (int'($urandom_range(0, 3)) * 33);
            if (r < 3) do_flush(1'($urandom_range(0, 1)));
            else if (r < 30) do_write(a, 8'($urandom), int'($urandom_range(0, 3)));
            else do_read(a, int'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
